wb_ram_arbiter: RTL and testbench

Round-robin Wishbone B4 bus arbiter that lets the CPU BFM, the DSP master and the DAQ master share one slave port, the wb_ram0 SRAM.
- Grant is locked for a master's whole cycle (cyc high), so classic and incrementing bursts are never split.
- An integrated watchdog terminates stalled cycles with err.
- Sits between the master ports of the intercon and the ram0 slave port.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_ram_arbiter_rr_pick.sv | 40 ++++
 rtl/wb_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the Wishbone RAM arbiter.
package wb_arb_pkg;

   // Wishbone B4 cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Wishbone B4 burst type extensions
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Arbiter ownership state: IDLE = no grant, OWNED = one master holds the slave
   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first asserted request at or
// after the priority pointer, scanning upward and wrapping to index 0.
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic          valid
);

   logic [N-1:0] hi_oh;
   logic [N-1:0] lo_oh;
   logic         hi_found;
   logic         lo_found;

   // Lowest request at/above the pointer wins; otherwise lowest request overall (wrap)
   always_comb begin
      hi_oh    = '0;
      lo_oh    = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_oh    = '0;
            lo_oh[i] = 1'b1;
            lo_found = 1'b1;
            if (i >= int'(ptr)) begin
               hi_oh    = '0;
               hi_oh[i] = 1'b1;
               hi_found = 1'b1;
            end
         end
      end
      pick  = hi_found ? hi_oh : lo_oh;
      valid = lo_found;
   end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing one RAM slave between several masters.
// Handshake: a master's request is its cyc; the slave sees the granted master's
// cyc/stb and completes each stb-qualified beat with exactly one of ack/err/rty,
// which is routed back only to the granted master. Grant is held for the whole
// cyc so bursts are never split; a watchdog ends beats that never get a response.
module wb_ram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst,
   input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
   output logic [DW-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [NUM_MASTERS-1:0]        m_rty_o,
   output logic [AW-1:0]                 s_adr_o,
   output logic [DW-1:0]                 s_dat_o,
   output logic [DW/8-1:0]               s_sel_o,
   output logic                          s_we_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic [2:0]                    s_cti_o,
   output logic [1:0]                    s_bte_o,
   input  logic [DW-1:0]                 s_dat_i,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   input  logic                          s_rty_i,
   output logic [NUM_MASTERS-1:0]        grant_o,
   output logic                          timeout_o
);

   localparam int          PW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int          SW     = DW / 8;
   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [15:0]            wd_q, wd_d;

   logic [NUM_MASTERS-1:0] pick;
   logic                   pick_valid;
   logic [PW-1:0]          rel_ptr;

   logic                   g_cyc, g_stb, g_we;
   logic [AW-1:0]          g_adr;
   logic [DW-1:0]          g_dat;
   logic [SW-1:0]          g_sel;
   logic [2:0]             g_cti;
   logic [1:0]             g_bte;
   logic                   resp;
   logic                   fire;

   rr_pick #(
      .N  (NUM_MASTERS),
      .PW (PW)
   ) u_rr_pick (
      .req   (m_cyc_i),
      .ptr   (ptr_q),
      .pick  (pick),
      .valid (pick_valid)
   );

   // AND-OR mux of the granted master's signals; all zero while nobody holds a grant
   always_comb begin
      g_cyc   = 1'b0;
      g_stb   = 1'b0;
      g_we    = 1'b0;
      g_adr   = '0;
      g_dat   = '0;
      g_sel   = '0;
      g_cti   = '0;
      g_bte   = '0;
      rel_ptr = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            g_cyc   = m_cyc_i[i];
            g_stb   = m_stb_i[i];
            g_we    = m_we_i[i];
            g_adr   = m_adr_i[i*AW +: AW];
            g_dat   = m_dat_i[i*DW +: DW];
            g_sel   = m_sel_i[i*SW +: SW];
            g_cti   = m_cti_i[i*3 +: 3];
            g_bte   = m_bte_i[i*2 +: 2];
            rel_ptr = (i == NUM_MASTERS - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   // A real slave response in the limit cycle beats the watchdog
   assign resp = s_ack_i | s_err_i | s_rty_i;
   assign fire = (state_q == OWNED) & g_cyc & g_stb & (wd_q == TO_CNT) & ~resp;

   assign s_cyc_o   = g_cyc & ~fire;
   assign s_stb_o   = g_stb & ~fire;
   assign s_we_o    = g_we;
   assign s_adr_o   = g_adr;
   assign s_dat_o   = g_dat;
   assign s_sel_o   = g_sel;
   assign s_cti_o   = g_cti;
   assign s_bte_o   = g_bte;

   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
   assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | fire}};
   assign m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i}};
   assign grant_o   = grant_q;
   assign timeout_o = fire;

   // Ownership FSM, pointer advance on release and watchdog counting
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      wd_d    = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = OWNED;
               grant_d = pick;
            end
         end
         OWNED: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = rel_ptr;
            end else if (!fire && s_stb_o && !resp) begin
               wd_d = wd_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: three master drivers, a small RAM slave, and a
// cycle model of ownership/round-robin/watchdog checked against the DUT.
module tb_wb_ram_arbiter;
   import wb_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic wb_clk = 1'b0;
   logic wb_rst = 1'b1;
   always #5 wb_clk = ~wb_clk;

   // ---------------- master side ----------------
   logic [AW-1:0] adr_r [N];
   logic [DW-1:0] dat_r [N];
   logic [SW-1:0] sel_r [N];
   logic          we_r  [N];
   logic          cyc_r [N];
   logic          stb_r [N];
   logic [2:0]    cti_r [N];
   logic [1:0]    bte_r [N];

   logic [N*AW-1:0] m_adr_i;
   logic [N*DW-1:0] m_dat_i;
   logic [N*SW-1:0] m_sel_i;
   logic [N-1:0]    m_we_i, m_cyc_i, m_stb_i;
   logic [N*3-1:0]  m_cti_i;
   logic [N*2-1:0]  m_bte_i;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         m_adr_i[k*AW +: AW] = adr_r[k];
         m_dat_i[k*DW +: DW] = dat_r[k];
         m_sel_i[k*SW +: SW] = sel_r[k];
         m_we_i[k]           = we_r[k];
         m_cyc_i[k]          = cyc_r[k];
         m_stb_i[k]          = stb_r[k];
         m_cti_i[k*3 +: 3]   = cti_r[k];
         m_bte_i[k*2 +: 2]   = bte_r[k];
      end
   end

   // ---------------- DUT outputs / slave side ----------------
   logic [DW-1:0] m_dat_o;
   logic [N-1:0]  m_ack_o, m_err_o, m_rty_o, grant_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [SW-1:0] s_sel_o;
   logic          s_we_o, s_cyc_o, s_stb_o, timeout_o;
   logic [2:0]    s_cti_o;
   logic [1:0]    s_bte_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i, s_err_i, s_rty_i;

   logic          auto_ack = 1'b0;
   logic          man_ack = 1'b0;
   logic          slave_auto = 1'b1;
   logic [DW-1:0] rdata_q = '0;
   logic [DW-1:0] mem [256];

   assign s_ack_i = auto_ack | man_ack;
   assign s_err_i = 1'b0;
   assign s_rty_i = 1'b0;
   assign s_dat_i = rdata_q;

   wb_ram_arbiter #(
      .NUM_MASTERS (N),
      .AW          (AW),
      .DW          (DW),
      .TIMEOUT     (TO)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .m_adr_i   (m_adr_i),
      .m_dat_i   (m_dat_i),
      .m_sel_i   (m_sel_i),
      .m_we_i    (m_we_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_cti_i   (m_cti_i),
      .m_bte_i   (m_bte_i),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rty_o   (m_rty_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_we_o    (s_we_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_cti_o   (s_cti_o),
      .s_bte_o   (s_bte_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_rty_i   (s_rty_i),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   // RAM slave: registered ack one cycle after each accepted stb
   always @(posedge wb_clk) begin
      if (wb_rst) begin
         auto_ack <= 1'b0;
      end else begin
         auto_ack <= slave_auto && s_cyc_o && s_stb_o && !auto_ack;
         if (s_cyc_o && s_stb_o) begin
            if (s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
            rdata_q <= mem[s_adr_o[9:2]];
         end
      end
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   logic        mon_on = 1'b0;
   logic [2:0]  seen_q [$];
   logic [2:0]  exp_q [$];
   logic [2:0]  prev_grant = '0;
   int          b2b = 0;
   int          ack_cnt [N];
   int          md_owner = -1;
   int          md_ptr = 0;
   int          md_stall = 0;
   logic [31:0] rdx [N];
   int          gwx [N];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner index, rotation pointer and stall count, checked every cycle
   always @(negedge wb_clk) begin : model
      automatic logic        fire_e = 1'b0;
      automatic logic [2:0]  g_e = '0;
      automatic logic [75:0] bus_e = '0;
      automatic logic        resp = s_ack_i | s_err_i | s_rty_i;
      automatic int          nxt = -1;
      if (mon_on) begin
         if (md_owner >= 0) begin
            fire_e = cyc_r[md_owner] && stb_r[md_owner] && (md_stall == TO) && !resp;
            g_e    = 3'(1 << md_owner);
            bus_e  = {cyc_r[md_owner] & ~fire_e, stb_r[md_owner] & ~fire_e, we_r[md_owner],
                      adr_r[md_owner], dat_r[md_owner], sel_r[md_owner], cti_r[md_owner],
                      bte_r[md_owner]};
         end
         check("grant", grant_o, g_e);
         check("slave_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o}, bus_e);
         check("resp", {m_ack_o, m_err_o, m_rty_o, timeout_o},
               {g_e & {3{s_ack_i}}, g_e & {3{s_err_i | fire_e}}, g_e & {3{s_rty_i}}, fire_e});
         check("rdata", m_dat_o, s_dat_i);
         for (int k = 0; k < N; k++) ack_cnt[k] += int'(m_ack_o[k]);
         if (grant_o != 3'b000 && grant_o != prev_grant) begin
            seen_q.push_back(grant_o);
            if (prev_grant != 3'b000) b2b++;
         end
         prev_grant = grant_o;
         if (wb_rst) begin
            md_owner = -1;
            md_ptr   = 0;
            md_stall = 0;
         end else if (md_owner < 0) begin
            md_stall = 0;
            for (int k = N - 1; k >= 0; k--) if (cyc_r[(md_ptr + k) % N]) nxt = (md_ptr + k) % N;
            md_owner = nxt;
         end else if (!cyc_r[md_owner]) begin
            md_ptr   = (md_owner + 1) % N;
            md_owner = -1;
            md_stall = 0;
         end else if (fire_e) begin
            md_stall = 0;
         end else if (stb_r[md_owner] && !resp) begin
            md_stall++;
         end else begin
            md_stall = 0;
         end
      end
   end

   task automatic compare_seq(input string tag);
      check({tag, "_len"}, 128'(seen_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) check(tag, seen_q[i], exp_q[i]);
      seen_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic reset_dut();
      wb_rst = 1'b1;
      repeat (2) @(posedge wb_clk);
      #1 wb_rst = 1'b0;
      mon_on = 1'b1;
   endtask

   task automatic wait_resp(input int k, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 300) begin
         @(negedge wb_clk);
         if (m_ack_o[k] || m_err_o[k]) ok = 1'b1;
         n++;
      end
      check("wait_resp", 128'(ok), 128'(1));
   endtask

   task automatic do_single(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int gw);
      bit seen_g = 1'b0;
      bit done = 1'b0;
      int n = 0;
      adr_r[k] = a; dat_r[k] = d; we_r[k] = we; sel_r[k] = 4'hF;
      cti_r[k] = CTI_CLASSIC; bte_r[k] = BTE_LINEAR;
      cyc_r[k] = 1'b1; stb_r[k] = 1'b1;
      gw = -1;
      rd = '0;
      while (!done && n < 300) begin
         @(negedge wb_clk);
         if (!seen_g && grant_o[k]) begin
            seen_g = 1'b1;
            gw = n;
         end
         if (m_ack_o[k] || m_err_o[k]) begin
            done = 1'b1;
            rd = m_dat_o;
         end
         n++;
      end
      check("single_wait", 128'(done), 128'(1));
      @(posedge wb_clk);
      #1 cyc_r[k] = 1'b0; stb_r[k] = 1'b0; we_r[k] = 1'b0;
      @(posedge wb_clk);
      #1;
   endtask

   task automatic do_burst(input int k, input logic [31:0] base, input int nb);
      bit ok;
      cyc_r[k] = 1'b1;
      for (int b = 0; b < nb; b++) begin
         adr_r[k] = base + 32'(4 * b);
         dat_r[k] = 32'hB000_0000 + 32'(b);
         we_r[k]  = 1'b1;
         sel_r[k] = 4'hF;
         bte_r[k] = BTE_LINEAR;
         cti_r[k] = (b == nb - 1) ? CTI_EOB : CTI_INCR;
         stb_r[k] = 1'b1;
         wait_resp(k, ok);
         @(posedge wb_clk);
         #1;
      end
      cyc_r[k] = 1'b0; stb_r[k] = 1'b0; we_r[k] = 1'b0;
      @(posedge wb_clk);
      #1;
   endtask

   // Wait (bounded) until the slave sees stb, leaving us at that cycle's negedge
   task automatic wait_stb(input string tag);
      int n = 0;
      do begin
         @(negedge wb_clk);
         n++;
      end while (!s_stb_o && n < 20);
      check(tag, 128'(s_stb_o), 128'(1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      int          gw;
      bit          ok;
      for (int k = 0; k < N; k++) begin
         adr_r[k] = '0; dat_r[k] = '0; sel_r[k] = '0; we_r[k] = 1'b0;
         cyc_r[k] = 1'b0; stb_r[k] = 1'b0; cti_r[k] = '0; bte_r[k] = '0;
         ack_cnt[k] = 0;
      end
      for (int i = 0; i < 256; i++) mem[i] = '0;

      // Reset values
      reset_dut();
      @(negedge wb_clk);
      check("rst_grant", grant_o, 3'b000);
      check("rst_ctrl", {s_cyc_o, s_stb_o, s_we_o, timeout_o}, 4'b0000);
      check("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 9'b0);
      @(posedge wb_clk);
      #1;

      // Single master 1 write then read
      for (int k = 0; k < N; k++) ack_cnt[k] = 0;
      do_single(1, 1'b1, 32'h100, 32'hDEAD_BEEF, rd, gw);
      check("t1_latency", 128'(gw), 128'(1));
      do_single(1, 1'b0, 32'h100, 32'h0, rd, gw);
      check("t1_rdata", rd, 32'hDEAD_BEEF);
      check("t1_ack1", 128'(ack_cnt[1]), 128'(2));
      check("t1_ack_other", 128'(ack_cnt[0] + ack_cnt[2]), 128'(0));

      // All three request together from reset
      reset_dut();
      seen_q.delete();
      b2b = 0;
      fork
         do_single(0, 1'b1, 32'h000, 32'h1111_1111, rdx[0], gwx[0]);
         do_single(1, 1'b1, 32'h004, 32'h2222_2222, rdx[1], gwx[1]);
         do_single(2, 1'b1, 32'h008, 32'h3333_3333, rdx[2], gwx[2]);
      join
      exp_q = '{3'b001, 3'b010, 3'b100};
      compare_seq("t2_order");
      check("t2_idle_gap", 128'(b2b), 128'(0));
      fork
         do_single(1, 1'b0, 32'h004, 32'h0, rdx[1], gwx[1]);
         do_single(0, 1'b0, 32'h008, 32'h0, rdx[0], gwx[0]);
      join
      exp_q = '{3'b001, 3'b010};
      compare_seq("t2_ptr_wrap");
      check("t2_rd0", rdx[0], 32'h3333_3333);
      check("t2_rd1", rdx[1], 32'h2222_2222);

      // Master 2 INCR burst, master 0 requests mid-burst
      fork
         do_burst(2, 32'h300, 4);
         begin
            repeat (3) @(posedge wb_clk);
            #1;
            do_single(0, 1'b0, 32'h304, 32'h0, rdx[0], gwx[0]);
         end
      join
      exp_q = '{3'b100, 3'b001};
      compare_seq("t3_order");
      check("t3_rd_beat1", rdx[0], 32'hB000_0001);
      check("t3_idle_gap", 128'(b2b), 128'(0));

      // Slave never answers: watchdog fires 8 stb cycles in
      slave_auto = 1'b0;
      adr_r[1] = 32'h40; we_r[1] = 1'b0; sel_r[1] = 4'hF; cti_r[1] = CTI_CLASSIC;
      cyc_r[1] = 1'b1; stb_r[1] = 1'b1;
      wait_stb("t4_stb_start");
      repeat (7) @(negedge wb_clk);
      check("t4_before", {timeout_o, m_err_o}, 4'b0000);
      @(negedge wb_clk);
      check("t4_timeout", 128'(timeout_o), 128'(1));
      check("t4_err", m_err_o, 3'b010);
      check("t4_stb_forced", {s_cyc_o, s_stb_o}, 2'b00);
      @(posedge wb_clk);
      #1 stb_r[1] = 1'b0;
      repeat (3) begin
         @(negedge wb_clk);
         check("t4_hold", grant_o, 3'b010);
      end
      @(posedge wb_clk);
      #1 cyc_r[1] = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1;

      // Ack arrives exactly when the count reaches the limit
      adr_r[0] = 32'h44; we_r[0] = 1'b0; sel_r[0] = 4'hF; cti_r[0] = CTI_CLASSIC;
      cyc_r[0] = 1'b1; stb_r[0] = 1'b1;
      wait_stb("t5_stb_start");
      check("t5_grant", grant_o, 3'b001);
      repeat (7) @(negedge wb_clk);
      @(posedge wb_clk);
      #1 man_ack = 1'b1;
      @(negedge wb_clk);
      check("t5_ack", m_ack_o, 3'b001);
      check("t5_no_err", {m_err_o, timeout_o}, 4'b0000);
      check("t5_stb", 128'(s_stb_o), 128'(1));
      @(posedge wb_clk);
      #1 man_ack = 1'b0; stb_r[0] = 1'b0; cyc_r[0] = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1 slave_auto = 1'b1;

      // Reset during beat 2 of a burst
      adr_r[2] = 32'h200; dat_r[2] = 32'hC0DE_0000; we_r[2] = 1'b1; sel_r[2] = 4'hF;
      cti_r[2] = CTI_INCR; cyc_r[2] = 1'b1; stb_r[2] = 1'b1;
      wait_resp(2, ok);
      @(posedge wb_clk);
      #1 adr_r[2] = 32'h204; dat_r[2] = 32'hC0DE_0001;
      wait_resp(2, ok);
      @(posedge wb_clk);
      #1 adr_r[2] = 32'h208; dat_r[2] = 32'hC0DE_0002; wb_rst = 1'b1;
      @(posedge wb_clk);
      #1 wb_rst = 1'b0; cyc_r[2] = 1'b0; stb_r[2] = 1'b0; we_r[2] = 1'b0;
      @(negedge wb_clk);
      check("t6_grant", grant_o, 3'b000);
      check("t6_scyc", {s_cyc_o, s_stb_o}, 2'b00);
      check("t6_resp", {m_ack_o, m_err_o, m_rty_o}, 9'b0);
      @(posedge wb_clk);
      #1;
      seen_q.delete();
      fork
         do_single(2, 1'b0, 32'h204, 32'h0, rdx[2], gwx[2]);
         do_single(0, 1'b0, 32'h200, 32'h0, rdx[0], gwx[0]);
      join
      exp_q = '{3'b001, 3'b100};
      compare_seq("t6_restart");
      check("t6_rd0", rdx[0], 32'hC0DE_0000);
      check("t6_rd2", rdx[2], 32'hC0DE_0001);

      repeat (2) @(posedge wb_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: run exceeded time limit");
      $fatal(1);
   end

endmodule
